// File: rtl/mem_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_ctrl_pkg : shared FSM state encoding, size codes and byte-count helper |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [2:0] size_to_count(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_arb.sv
// +----------------------------------------------------------------------------+
// | mem_ctrl_arb : picks one of the ls/fetch requests, one-hot grant {if, ls}  |
// | Option       : MEM_CTRL_RR_ARB_EN selects round-robin, else ls priority    |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mem_ctrl_arb (
  input  logic       ls_req_i,
  input  logic       if_req_i,
  input  logic       last_if_i,
  output logic [1:0] grant_o
);

`ifdef MEM_CTRL_RR_ARB_EN
  // On contention the port that was not served last wins.
  always_comb begin
    grant_o = 2'b00;
    if (ls_req_i && if_req_i) begin
      grant_o = last_if_i ? 2'b01 : 2'b10;
    end else if (ls_req_i) begin
      grant_o = 2'b01;
    end else if (if_req_i) begin
      grant_o = 2'b10;
    end
  end
`else
  logic unused_last_if;
  assign unused_last_if = last_if_i;

  always_comb begin
    grant_o = 2'b00;
    if (ls_req_i) begin
      grant_o = 2'b01;
    end else if (if_req_i) begin
      grant_o = 2'b10;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// +----------------------------------------------------------------------------+
// | mem_ctrl : byte-serial RAM controller serving a fetch and a load/store port|
// | Option   : MEM_CTRL_RR_ARB_EN enables round-robin arbitration              |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  output logic                  mem_en_out,
  output logic                  mem_r_nw_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic [7:0]            mem_d_out,
  input  logic [7:0]            mem_d_in,
  input  logic                  if_req_in,
  input  logic [31:0]           if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_we_in,
  input  logic [1:0]            ls_size_in,
  input  logic [31:0]           ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out
);

  state_e                state_q;
  logic [2:0]            cnt_q;
  logic [2:0]            n_q;
  logic                  is_if_q;
  logic                  last_if_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;
  logic [31:0]           buf_d;
  logic                  mem_en_q;
  logic                  mem_r_nw_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_d_q;
  logic                  if_done_q;
  logic                  ls_done_q;
  logic [31:0]           if_data_q;
  logic [31:0]           ls_data_q;

  logic [1:0]            grant;
  logic                  acc_if;
  logic                  acc_we;
  logic [2:0]            acc_n;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [2:0]            cnt_inc;
  logic [1:0]            cap_idx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            next_byte;
  logic                  unused_addr_hi;

  mem_ctrl_arb u_arb (
    .ls_req_i  (ls_req_in),
    .if_req_i  (if_req_in),
    .last_if_i (last_if_q),
    .grant_o   (grant)
  );

  assign acc_if         = grant[1];
  assign acc_we         = ~acc_if & ls_we_in;
  assign acc_n          = acc_if ? 3'd4 : size_to_count(ls_size_in);
  assign acc_addr       = acc_if ? if_addr_in[ADDR_WIDTH-1:0] : ls_addr_in[ADDR_WIDTH-1:0];
  assign cnt_inc        = cnt_q + 3'd1;
  assign cap_idx        = 2'(cnt_q - 3'd1);
  assign next_addr      = base_q + ADDR_WIDTH'(cnt_inc);
  assign next_byte      = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
  assign unused_addr_hi = ^{if_addr_in[31:ADDR_WIDTH], ls_addr_in[31:ADDR_WIDTH]};

  // Read data lags the issue by one cycle, so count c captures byte c-1.
  always_comb begin
    buf_d = buf_q;
    buf_d[{cap_idx, 3'b000} +: 8] = mem_d_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      is_if_q    <= 1'b0;
      last_if_q  <= 1'b1;
      base_q     <= '0;
      wdata_q    <= 32'h0;
      buf_q      <= 32'h0;
      mem_en_q   <= 1'b0;
      mem_r_nw_q <= 1'b1;
      mem_a_q    <= '0;
      mem_d_q    <= 8'h00;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= 32'h0;
      ls_data_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            is_if_q    <= acc_if;
            last_if_q  <= acc_if;
            n_q        <= acc_n;
            base_q     <= acc_addr;
            wdata_q    <= ls_wdata_in;
            buf_q      <= 32'h0;
            cnt_q      <= 3'd0;
            mem_en_q   <= 1'b1;
            mem_r_nw_q <= ~acc_we;
            mem_a_q    <= acc_addr;
            mem_d_q    <= acc_we ? ls_wdata_in[7:0] : 8'h00;
            state_q    <= acc_we ? WRITE : READ;
          end
        end
        READ: begin
          if (cnt_q != 3'd0) begin
            buf_q <= buf_d;
          end
          if (cnt_q == n_q) begin
            state_q <= DONE;
            if (is_if_q) begin
              if_data_q <= buf_d;
              if_done_q <= 1'b1;
            end else begin
              ls_data_q <= buf_d;
              ls_done_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc < n_q) begin
              mem_a_q <= next_addr;
            end else begin
              mem_en_q <= 1'b0;
              mem_a_q  <= '0;
            end
          end
        end
        WRITE: begin
          if (cnt_inc < n_q) begin
            cnt_q   <= cnt_inc;
            mem_a_q <= next_addr;
            mem_d_q <= next_byte;
          end else begin
            mem_en_q   <= 1'b0;
            mem_r_nw_q <= 1'b1;
            mem_a_q    <= '0;
            mem_d_q    <= 8'h00;
            state_q    <= DONE;
            if (is_if_q) begin
              if_done_q <= 1'b1;
            end else begin
              ls_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if_done_q <= 1'b0;
          ls_done_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en_out   = mem_en_q;
  assign mem_r_nw_out = mem_r_nw_q;
  assign mem_a_out    = mem_a_q;
  assign mem_d_out    = mem_d_q;
  assign if_done_out  = if_done_q;
  assign if_data_out  = if_data_q;
  assign ls_done_out  = ls_done_q;
  assign ls_rdata_out = ls_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_mem_ctrl : directed self-checking bench for mem_ctrl with a RAM model   |
// | Option      : MEM_CTRL_RR_ARB_EN switches the expected arbitration order   |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mem_ctrl;

  localparam int AW = 17;

  typedef struct {
    int          cyc;
    logic [16:0] a;
    logic        rnw;
    logic [7:0]  d;
  } acc_t;

  logic          clk;
  logic          rst_n_in;
  logic          mem_en_out;
  logic          mem_r_nw_out;
  logic [AW-1:0] mem_a_out;
  logic [7:0]    mem_d_out;
  logic [7:0]    mem_d_in;
  logic          if_req_in;
  logic [31:0]   if_addr_in;
  logic          if_done_out;
  logic [31:0]   if_data_out;
  logic          ls_req_in;
  logic          ls_we_in;
  logic [1:0]    ls_size_in;
  logic [31:0]   ls_addr_in;
  logic [31:0]   ls_wdata_in;
  logic          ls_done_out;
  logic [31:0]   ls_rdata_out;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic both_done = 1'b0;
  logic bad_idle  = 1'b0;
  logic [7:0] ram [0:(1<<AW)-1];
  acc_t acc_q[$];

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n_in),
    .mem_en_out   (mem_en_out),
    .mem_r_nw_out (mem_r_nw_out),
    .mem_a_out    (mem_a_out),
    .mem_d_out    (mem_d_out),
    .mem_d_in     (mem_d_in),
    .if_req_in    (if_req_in),
    .if_addr_in   (if_addr_in),
    .if_done_out  (if_done_out),
    .if_data_out  (if_data_out),
    .ls_req_in    (ls_req_in),
    .ls_we_in     (ls_we_in),
    .ls_size_in   (ls_size_in),
    .ls_addr_in   (ls_addr_in),
    .ls_wdata_in  (ls_wdata_in),
    .ls_done_out  (ls_done_out),
    .ls_rdata_out (ls_rdata_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_d_in <= 8'h00;
    if (mem_en_out && !mem_r_nw_out) ram[mem_a_out] <= mem_d_out;
    if (mem_en_out && mem_r_nw_out)  mem_d_in <= ram[mem_a_out];
  end

  always @(negedge clk) begin
    if (mem_en_out) acc_q.push_back('{cyc: cyc, a: mem_a_out, rnw: mem_r_nw_out, d: mem_d_out});
    if (if_done_out && ls_done_out) both_done <= 1'b1;
    if (!mem_en_out && (mem_a_out != '0 || mem_d_out != 8'h00 || !mem_r_nw_out)) bad_idle <= 1'b1;
  end

  task automatic run_if(input logic [31:0] addr, output logic [31:0] data, output int k, output int lat);
    bit got = 0;
    @(negedge clk);
    if_addr_in = addr;
    if_req_in  = 1'b1;
    k = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_done_out) got = 1;
    end
    if_req_in = 1'b0;
    lat  = got ? cyc - k : -1;
    data = if_data_out;
    if (!got) begin
      checks++; errors++;
      $display("FAIL if_timeout addr=%h no done within 40 cycles", addr);
    end
  endtask

  task automatic run_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] data, output int k, output int lat);
    bit got = 0;
    @(negedge clk);
    ls_we_in    = we;
    ls_size_in  = size;
    ls_addr_in  = addr;
    ls_wdata_in = wdata;
    ls_req_in   = 1'b1;
    k = cyc;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ls_done_out) got = 1;
    end
    ls_req_in = 1'b0;
    lat  = got ? cyc - k : -1;
    data = ls_rdata_out;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ls_timeout addr=%h no done within 40 cycles", addr);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_en_out, mem_r_nw_out, mem_d_out} !== {1'b0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL reset_mem_ctl got en=%b rnw=%b d=%h exp en=0 rnw=1 d=00", mem_en_out, mem_r_nw_out, mem_d_out);
    end
    checks++;
    if (mem_a_out !== '0) begin
      errors++; $display("FAIL reset_addr got %h exp 0", mem_a_out);
    end
    checks++;
    if ({if_done_out, ls_done_out, if_data_out, ls_rdata_out} !== 66'h0) begin
      errors++; $display("FAIL reset_ports got ifd=%b lsd=%b ifdata=%h lsdata=%h exp all 0",
                         if_done_out, ls_done_out, if_data_out, ls_rdata_out);
    end
    rst_n_in = 1'b1;
  endtask

  task automatic test_byte_store;
    logic [31:0] rd; int k, lat, i0;
    i0 = acc_q.size();
    run_ls(1'b1, 2'd0, 32'h0001FFFF, 32'h000000AB, rd, k, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL byte_store_latency got %0d exp 2", lat); end
    checks++;
    if (acc_q.size() - i0 != 1) begin
      errors++; $display("FAIL byte_store_count got %0d exp 1", acc_q.size() - i0);
    end else begin
      checks++;
      if (acc_q[i0].cyc - k != 1 || acc_q[i0].a != 17'h1FFFF || acc_q[i0].rnw != 1'b0 || acc_q[i0].d != 8'hAB) begin
        errors++; $display("FAIL byte_store_access got off=%0d a=%h rnw=%b d=%h exp off=1 a=1ffff rnw=0 d=ab",
                           acc_q[i0].cyc - k, acc_q[i0].a, acc_q[i0].rnw, acc_q[i0].d);
      end
    end
    checks++;
    if (ram[17'h1FFFF] !== 8'hAB) begin errors++; $display("FAIL byte_store_ram got %h exp ab", ram[17'h1FFFF]); end
  endtask

  task automatic test_wrap_store;
    logic [31:0] rd; int k, lat, i0;
    logic [16:0] ea [4];
    logic [7:0]  ed [4];
    ea[0] = 17'h1FFFE; ea[1] = 17'h1FFFF; ea[2] = 17'h00000; ea[3] = 17'h00001;
    ed[0] = 8'hEF;     ed[1] = 8'hBE;     ed[2] = 8'hAD;     ed[3] = 8'hDE;
    i0 = acc_q.size();
    run_ls(1'b1, 2'd2, 32'h0001FFFE, 32'hDEADBEEF, rd, k, lat);
    checks++;
    if (lat != 5) begin errors++; $display("FAIL wrap_store_latency got %0d exp 5", lat); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i0 + i >= acc_q.size() || acc_q[i0+i].cyc - k != 1 + i || acc_q[i0+i].a != ea[i] ||
          acc_q[i0+i].rnw != 1'b0 || acc_q[i0+i].d != ed[i]) begin
        errors++; $display("FAIL wrap_store_byte%0d got a=%h d=%h exp a=%h d=%h", i,
                           acc_q[i0+i].a, acc_q[i0+i].d, ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_word_load_wrap;
    logic [31:0] rd; int k, lat;
    run_ls(1'b0, 2'd3, 32'h0001FFFE, 32'h0, rd, k, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wrap_load_data got %h exp deadbeef", rd); end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL wrap_load_latency got %0d exp 6", lat); end
  endtask

  task automatic test_fetch;
    logic [31:0] rd; int k, lat, i0;
    run_ls(1'b1, 2'd2, 32'h00000100, 32'h44332211, rd, k, lat);
    i0 = acc_q.size();
    run_if(32'h00000100, rd, k, lat);
    checks++;
    if (rd !== 32'h44332211) begin errors++; $display("FAIL fetch_data got %h exp 44332211", rd); end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL fetch_latency got %0d exp 6", lat); end
    checks++;
    if (acc_q.size() - i0 != 4) begin errors++; $display("FAIL fetch_count got %0d exp 4", acc_q.size() - i0); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i0 + i >= acc_q.size() || acc_q[i0+i].cyc - k != 1 + i ||
          acc_q[i0+i].a != 17'h100 + 17'(i) || acc_q[i0+i].rnw != 1'b1) begin
        errors++; $display("FAIL fetch_issue%0d got off=%0d a=%h rnw=%b exp off=%0d a=%h rnw=1", i,
                           acc_q[i0+i].cyc - k, acc_q[i0+i].a, acc_q[i0+i].rnw, 1 + i, 17'h100 + 17'(i));
      end
    end
  endtask

  task automatic test_half_load;
    logic [31:0] rd; int k, lat, i0;
    run_ls(1'b1, 2'd2, 32'h00000200, 32'hFFFFA55A, rd, k, lat);
    i0 = acc_q.size();
    run_ls(1'b0, 2'd1, 32'h00000200, 32'h0, rd, k, lat);
    checks++;
    if (rd !== 32'h0000A55A) begin errors++; $display("FAIL half_load_data got %h exp 0000a55a", rd); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL half_load_latency got %0d exp 4", lat); end
    checks++;
    if (acc_q.size() - i0 != 2) begin errors++; $display("FAIL half_load_count got %0d exp 2", acc_q.size() - i0); end
    checks++;
    if (if_data_out !== 32'h44332211) begin errors++; $display("FAIL if_data_hold got %h exp 44332211", if_data_out); end
  endtask

  task automatic test_back_to_back;
`ifdef MEM_CTRL_RR_ARB_EN
    localparam int PAIRS = 3;
`else
    localparam int PAIRS = 1;
`endif
    int order[$];
    int ls_bad = 0, if_bad = 0;
    @(negedge clk); rst_n_in = 1'b0;
    @(negedge clk); rst_n_in = 1'b1;
    fork
      begin
        logic [31:0] d; int k, l;
        for (int p = 0; p < PAIRS; p++) begin
          run_ls(1'b0, 2'd2, 32'h00000100, 32'h0, d, k, l);
          order.push_back(0);
          if (d !== 32'h44332211) ls_bad++;
        end
      end
      begin
        logic [31:0] d; int k, l;
        for (int p = 0; p < PAIRS; p++) begin
          run_if(32'h0001FFFE, d, k, l);
          order.push_back(1);
          if (d !== 32'hDEADBEEF) if_bad++;
        end
      end
    join
    checks++;
    if (order.size() != 2 * PAIRS) begin errors++; $display("FAIL b2b_count got %0d exp %0d", order.size(), 2 * PAIRS); end
    for (int i = 0; i < 2 * PAIRS; i++) begin
      checks++;
      if (i >= order.size() || order[i] != i % 2) begin
        errors++; $display("FAIL b2b_order slot %0d got %0d exp %0d (0=ls 1=if)", i, order[i], i % 2);
      end
    end
    checks++;
    if (ls_bad != 0 || if_bad != 0) begin errors++; $display("FAIL b2b_data got bad ls=%0d if=%0d exp 0", ls_bad, if_bad); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int k, lat;
    logic saw_done = 1'b0;
    @(negedge clk);
    if_addr_in = 32'h00000100;
    if_req_in  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_en_out !== 1'b1) begin errors++; $display("FAIL mid_pre_reset_en got %b exp 1", mem_en_out); end
    rst_n_in  = 1'b0;
    if_req_in = 1'b0;
    #1;
    checks++;
    if (mem_en_out !== 1'b0 || mem_r_nw_out !== 1'b1 || mem_a_out !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got en=%b rnw=%b a=%h exp en=0 rnw=1 a=0", mem_en_out, mem_r_nw_out, mem_a_out);
    end
    repeat (2) @(negedge clk);
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_done_out || ls_done_out || mem_en_out) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL mid_reset_quiet got activity after abandoned read exp none"); end
    run_if(32'h00000100, rd, k, lat);
    checks++;
    if (rd !== 32'h44332211 || lat != 6) begin
      errors++; $display("FAIL post_reset_fetch got data=%h lat=%0d exp 44332211 6", rd, lat);
    end
  endtask

  task automatic test_invariants;
    checks++;
    if (both_done !== 1'b0) begin errors++; $display("FAIL dual_done got 1 exp 0"); end
    checks++;
    if (bad_idle !== 1'b0) begin errors++; $display("FAIL idle_outputs got nonzero idle bus exp quiet"); end
  endtask

  initial begin
    rst_n_in    = 1'b0;
    if_req_in   = 1'b0;
    if_addr_in  = 32'h0;
    ls_req_in   = 1'b0;
    ls_we_in    = 1'b0;
    ls_size_in  = 2'd0;
    ls_addr_in  = 32'h0;
    ls_wdata_in = 32'h0;
    test_reset();
    test_byte_store();
    test_wrap_store();
    test_word_load_wrap();
    test_fetch();
    test_half_load();
    test_back_to_back();
    test_reset_mid();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, giving the RAM byte-address width.
REQ-002 SHALL have clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n_in  input  1  asynchronous, active-low reset.
REQ-004 SHALL have mem_en_out  output  1  RAM chip enable.
REQ-005 SHALL have mem_r_nw_out  output  1  RAM read/write select: read 1, write 0.
REQ-006 SHALL have mem_a_out  output  ADDR_WIDTH  RAM byte address.
REQ-007 SHALL have mem_d_out  output  8  RAM write data.
REQ-008 SHALL have mem_d_in  input  8  RAM read data, valid the cycle after a read is issued.
REQ-009 SHALL have if_req_in  input  1, if_addr_in  input  32, if_done_out  output  1, if_data_out  output  32: fetch port, 4-byte reads only.
REQ-010 SHALL have ls_req_in  input  1, ls_we_in  input  1, ls_size_in  input  2, ls_addr_in  input  32, ls_wdata_in  input  32, ls_done_out  output  1, ls_rdata_out  output  32: load/store port.

Function
REQ-011 SHALL use states IDLE, READ, WRITE, DONE.
REQ-012 SHALL sample requests only in IDLE; a requester holds req and operands stable until it sees done.
REQ-013 SHALL set byte count N from ls_size_in: 0 -> 1, 1 -> 2, 2 or 3 -> 4; the fetch port always uses N=4.
REQ-014 SHALL access bytes little-endian: byte i goes to address addr+i and occupies data bits [8i+7:8i].
REQ-015 SHALL truncate addresses to ADDR_WIDTH bits, so addr+i wraps modulo 2^ADDR_WIDTH; misaligned addresses are legal.
REQ-016 SHALL, for a request accepted at the edge ending cycle k, drive byte i with en=1 in cycle k+1+i, for i = 0..N-1.
REQ-017 SHALL, on a read, capture mem_d_in in cycles k+2 .. k+N+1, then assert done with the data in cycle k+N+2.
REQ-018 SHALL, on a write, drive r_nw=0 with mem_d_out = the byte, then assert done in cycle k+N+1.
REQ-019 SHALL hold done high for exactly one cycle (the DONE state) and then return to IDLE.
REQ-020 SHALL keep if_data_out and ls_rdata_out valid from DONE until the next completion on the same port; bytes not read SHALL be zero.
REQ-021 SHALL drive mem_en_out=0, mem_r_nw_out=1, mem_a_out=0 and mem_d_out=0 whenever no byte is being issued.
REQ-022 SHALL never assert if_done_out and ls_done_out in the same cycle.

Reset
REQ-023 SHALL, while rst_n_in is low, immediately force state to IDLE and all outputs to 0, except mem_r_nw_out, which is forced to 1.
REQ-024 SHALL abandon any access in progress on reset; bytes already written stay written, and no done is generated.

Configuration
REQ-025 SHALL, with MEM_CTRL_RR_ARB_EN defined, arbitrate requests that are both pending in IDLE round-robin, favouring the port not served last; after reset the ls port is favoured.
REQ-026 SHALL, without MEM_CTRL_RR_ARB_EN, give the ls port fixed priority over the fetch port.

Structure
REQ-027 SHALL take the state encoding and the size codes (BYTE=0, HALF=1, WORD=2) from a shared package, mem_ctrl_pkg.
REQ-028 SHALL implement arbitration in one sub-module, mem_ctrl_arb, with inputs the two requests plus the last-served flag and a one-hot grant output.

Verification
REQ-029 SHALL cover a fetch word read: RAM[0x100..0x103] = 11,22,33,44, if_req accepted at k -> en in k+1..k+4, if_data_out = 0x44332211 with if_done_out in k+6.
REQ-030 SHALL cover a byte store: ls_we=1, size=0, addr=0x1FFFF, wdata=0x000000AB -> one write cycle at 0x1FFFF with data 0xAB, ls_done_out in k+2.
REQ-031 SHALL cover a wrapping word store: addr=0x1FFFE, wdata=0xDEADBEEF -> EF@0x1FFFE, BE@0x1FFFF, AD@0x00000, DE@0x00001.
REQ-032 SHALL cover a halfword load of 0xA55A -> ls_rdata_out = 0x0000A55A with the upper bytes zero.
REQ-033 SHALL cover simultaneous requests from both ports: without the macro, ls is served first, then if; with MEM_CTRL_RR_ARB_EN, three back-to-back pairs are served ls, if, ls, if, ls, if.
REQ-034 SHALL cover reset asserted in cycle k+2 of a word read: mem_en_out drops to 0 at once, no done follows, and the next request after reset completes normally.
